// File: rtl/mvu_pe_acc_if.sv
// mvu_pe_acc_if: valid/ready stream carrying one W-bit word per beat
//   v     valid, driven by the master
//   rdy   ready, driven by the slave
//   data  payload, driven by the master; a beat transfers when v && rdy at an edge
interface mvu_pe_acc_if #(parameter int W = 8);
   logic v;
   logic rdy;
   logic [W-1:0] data;
   modport master (output v, data, input rdy);
   modport slave (input v, data, output rdy);
endinterface

// File: rtl/mvu_pe_acc.sv
// mvu_pe_acc: folds SF partial sums into one dot-product result held on a valid/ready output
//   aclk     clock, all state on the rising edge
//   aresetn  synchronous active-low reset
//   src      slave stream, TI-bit partial sums from the SIMD adder (v, rdy, data)
//   dst      master stream, TO-bit accumulated results to the output stage (v, rdy, data)
module mvu_pe_acc #(
   parameter int TI   = 2,
   parameter int TO   = 16,
   parameter int SF   = 4,
   parameter int TSGN = 1
) (
   input logic          aclk,
   input logic          aresetn,
   mvu_pe_acc_if.slave  src,
   mvu_pe_acc_if.master dst
);
   localparam int CW = SF > 1 ? $clog2(SF) : 1;
   typedef enum logic {ACC, HOLD} state_t;
   state_t state, state_nx;
   logic [CW-1:0] sf_cnt;
   logic [TO-1:0] acc, out_acc, ext, sum;
   logic last, take, fin;
   assign last = sf_cnt == CW'(SF - 1);
   // only a final beat can stall, and only while the previous result is still unconsumed
   assign src.rdy = !(last && state == HOLD && !dst.rdy);
   assign take = src.v && src.rdy;
   assign fin = take && last;
   // the replicated top bits are the sign for signed input and zero otherwise
   assign ext = TO'({{TO{TSGN != 0 && src.data[TI-1]}}, src.data});
   // the first beat of a fold starts from zero rather than from acc
   assign sum = (sf_cnt == '0 ? '0 : acc) + ext;
   assign dst.v = state == HOLD;
   assign dst.data = out_acc;
   always_ff @(posedge aclk)
      if (!aresetn) state <= ACC;
      else state <= state_nx;
   // a consume and a new final beat at the same edge keep HOLD, giving back-to-back results
   always_comb begin
      state_nx = state;
      if (state == ACC && fin) state_nx = HOLD;
      if (state == HOLD && dst.rdy && !fin) state_nx = ACC;
   end
   always_ff @(posedge aclk)
      if (!aresetn) begin
         sf_cnt <= '0;
         acc <= '0;
         out_acc <= '0;
      end else if (fin) begin
         out_acc <= sum;
         acc <= '0;
         sf_cnt <= '0;
      end else if (take) begin
         acc <= sum;
         sf_cnt <= sf_cnt + 1'b1;
      end
endmodule

// File: tb/tb_mvu_pe_acc.sv
// tb_mvu_pe_acc: randomized and directed checks of mvu_pe_acc against a fold-level reference model
module tb_mvu_pe_acc;
   logic aclk = 0;
   logic aresetn = 0;
   always #5 aclk = ~aclk;
   int total = 0;
   int bad = 0;
   mvu_pe_acc_if #(4)  ai();
   mvu_pe_acc_if #(16) ao();
   mvu_pe_acc_if #(4)  bi();
   mvu_pe_acc_if #(5)  bo();
   mvu_pe_acc_if #(4)  ci();
   mvu_pe_acc_if #(16) co();
   mvu_pe_acc #(.TI(4), .TO(16), .SF(4), .TSGN(1)) dut_a (.aclk(aclk), .aresetn(aresetn), .src(ai), .dst(ao));
   mvu_pe_acc #(.TI(4), .TO(5),  .SF(4), .TSGN(0)) dut_b (.aclk(aclk), .aresetn(aresetn), .src(bi), .dst(bo));
   mvu_pe_acc #(.TI(4), .TO(16), .SF(1), .TSGN(1)) dut_c (.aclk(aclk), .aresetn(aresetn), .src(ci), .dst(co));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // reference model for dut_a: beats counted per fold, completed sums queued until consumed
   int nb = 0;
   logic [15:0] part = '0;
   logic [15:0] q[$];
   bit sb_on = 0;
   always @(negedge aclk) if (sb_on) begin
      logic exp_rdy;
      int d;
      exp_rdy = !(nb == 3 && q.size() != 0 && !ao.rdy);
      chk("a_in_rdy", ai.rdy, exp_rdy);
      chk("a_out_v", ao.v, q.size() != 0);
      if (q.size() != 0) chk("a_out_acc", ao.data, q[0]);
      if (!aresetn) begin
         nb = 0;
         part = '0;
         q.delete();
      end else begin
         if (q.size() != 0 && ao.rdy) void'(q.pop_front());
         if (ai.v && exp_rdy) begin
            d = $signed(ai.data);
            part = part + 16'(d);
            nb++;
            if (nb == 4) begin
               q.push_back(part);
               nb = 0;
               part = '0;
            end
         end
      end
   end

   task automatic send_a(input logic [3:0] val);
      int n = 0;
      ai.v = 1;
      ai.data = val;
      @(negedge aclk);
      while (!ai.rdy && n < 50) begin
         @(negedge aclk);
         n++;
      end
      if (n == 50) chk("a_stall_timeout", 1, 0);
      tick();
      ai.v = 0;
   endtask

   initial begin
      ai.v = 0; ai.data = '0; ao.rdy = 1;
      bi.v = 0; bi.data = '0; bo.rdy = 1;
      ci.v = 0; ci.data = '0; co.rdy = 1;
      repeat (2) tick();
      chk("rst_out_v", ao.v, 0);
      chk("rst_out_acc", ao.data, 0);
      chk("rst_in_rdy", ai.rdy, 1);
      aresetn = 1;
      sb_on = 1;
      bi.v = 1; bi.data = 4'd15;
      repeat (4) tick();
      bi.v = 0;
      chk("b_wrap_v", bo.v, 1);
      chk("b_wrap_acc", bo.data, 28);
      ci.v = 1; ci.data = 4'hF;
      tick();
      chk("c_sf1_v0", co.v, 1);
      chk("c_sf1_acc0", co.data, 16'hFFFF);
      ci.data = 4'd4;
      tick();
      ci.v = 0;
      chk("c_sf1_v1", co.v, 1);
      chk("c_sf1_acc1", co.data, 4);
      tick();
      chk("c_sf1_idle", co.v, 0);
      send_a(4'd3); send_a(4'hE); send_a(4'd5); send_a(4'd1);
      chk("a_basic_v", ao.v, 1);
      chk("a_basic_acc", ao.data, 7);
      tick();
      chk("a_basic_once", ao.v, 0);
      ao.rdy = 0;
      send_a(4'd3); send_a(4'hE); send_a(4'd5); send_a(4'd1);
      send_a(4'd1); send_a(4'd1); send_a(4'd1);
      ai.v = 1; ai.data = 4'd1;
      repeat (6) begin
         @(negedge aclk);
         chk("a_stall_rdy", ai.rdy, 0);
         chk("a_stall_hold", ao.data, 7);
      end
      tick();
      ao.rdy = 1;
      @(negedge aclk);
      chk("a_release_rdy", ai.rdy, 1);
      tick();
      ai.v = 0;
      chk("a_b2b_v", ao.v, 1);
      chk("a_b2b_acc", ao.data, 4);
      tick();
      chk("a_b2b_done", ao.v, 0);
      ai.v = 1; ai.data = 4'd2;
      for (int i = 1; i <= 12; i++) begin
         @(negedge aclk);
         chk("a_stream_rdy", ai.rdy, 1);
         tick();
         chk("a_stream_v", ao.v, i % 4 == 0);
      end
      ai.v = 0;
      tick();
      send_a(4'd7); send_a(4'd7);
      aresetn = 0;
      tick();
      chk("a_midrst_v", ao.v, 0);
      chk("a_midrst_rdy", ai.rdy, 1);
      aresetn = 1;
      send_a(4'd2); send_a(4'd2); send_a(4'd2); send_a(4'd2);
      chk("a_midrst_acc", ao.data, 8);
      chk("a_midrst_res_v", ao.v, 1);
      for (int i = 0; i < 3000; i++) begin
         ai.v = ($urandom % 10) < 7;
         ai.data = 4'($urandom);
         ao.rdy = ($urandom % 10) < 6;
         aresetn = ($urandom % 100) != 0;
         tick();
      end
      aresetn = 1;
      ai.v = 0;
      ao.rdy = 1;
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
